// File: rtl/shape_processor_pkg.sv
// Purpose: shared CTRL SFR layout, shape/operation encodings and sequencer status codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shape_processor_pkg;

  // Field positions inside the 32-bit CTRL word
  localparam int FIELD_W   = 4;
  localparam int SHAPE_LSB = 0;
  localparam int OP_LSB    = 4;

  typedef enum logic [FIELD_W-1:0] {
    SHAPE_NONE   = 4'd0,
    SHAPE_RECT   = 4'd1,
    SHAPE_CIRCLE = 4'd2,
    SHAPE_TRI    = 4'd3
  } shape_e;

  typedef enum logic [FIELD_W-1:0] {
    OP_NOP    = 4'd0,
    OP_FILL   = 4'd1,
    OP_STROKE = 4'd2,
    OP_CLEAR  = 4'd3
  } operation_e;

  // CTRL SFR word: [31:8] reserved, [7:4] OPERATION, [3:0] SHAPE
  typedef struct packed {
    logic [23:0] rsvd;
    operation_e  operation;
    shape_e      shape;
  } ctrl_sfr_reg;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    REJECTED = 2'd1,
    MISMATCH = 2'd2
  } seq_status_e;

endpackage

// File: rtl/shape_processor_cmd_sequencer_if.sv
// Purpose: bundles requester handshake, status and SFR port signals of the sequencer.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until their gnt pulse; the SFR side never stalls.
interface shape_processor_cmd_sequencer_if
  import shape_processor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    gnt;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  seq_status_e           done_status;
  logic                  busy;
  logic [CNT_W-1:0]      reject_cnt;
  logic                  write;
  logic [31:0]           write_data;
  logic                  read;
  logic [31:0]           read_data;
  logic                  error;

  // Sequencer side
  modport slave (
    input  req, req_data, read_data, error,
    output gnt, done, done_id, done_status, busy, reject_cnt, write, write_data, read
  );

  // Requesters plus shape_processor side
  modport master (
    output req, req_data, read_data, error,
    input  gnt, done, done_id, done_status, busy, reject_cnt, write, write_data, read
  );
endinterface

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is used.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  // Scan from ptr upward with wrap; first hit wins
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/shape_processor_cmd_sequencer.sv
// Purpose: arbitrates requesters onto one CTRL SFR port; write, error check, readback, status.
// Latency: gnt at c0, done at c3 (OK/MISMATCH) or c2 (REJECTED); one command in flight.
// Backpressure: requesters hold req until gnt; no new grant until the sequencer is back in IDLE.
module shape_processor_cmd_sequencer
  import shape_processor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input logic                           clk,
  input logic                           rst_n,
  shape_processor_cmd_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  ctrl_sfr_reg        word_q, word_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  seq_status_e        status_q, status_d;
  logic [CNT_W-1:0]   reject_cnt_q, reject_cnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_vld;
  logic               fields_match;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Only SHAPE and OPERATION must read back; reserved bits are free to differ
  assign fields_match = (bus.read_data[SHAPE_LSB +: FIELD_W] == word_q.shape) &&
                        (bus.read_data[OP_LSB +: FIELD_W] == word_q.operation);

  // Command sequencing, pointer advance and reject counting
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    status_d     = status_q;
    reject_cnt_d = reject_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          word_d   = ctrl_sfr_reg'(bus.req_data[32*int'(arb_idx) +: 32]);
          id_d     = arb_idx;
          rr_ptr_d = (int'(arb_idx) == NUM_REQ-1) ? '0 : arb_idx + 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (bus.error) begin
          status_d = REJECTED;
          state_d  = RESP;
        end else begin
          state_d  = READ;
        end
      end
      READ: begin
        status_d = fields_match ? OK : MISMATCH;
        state_d  = RESP;
      end
      RESP: begin
        if (status_q == REJECTED && reject_cnt_q != {CNT_W{1'b1}}) begin
          reject_cnt_d = reject_cnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      status_q     <= OK;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      status_q     <= status_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  // Grant is masked while reset is held so every output reads 0 in reset
  assign bus.gnt         = (state_q == IDLE && rst_n) ? arb_gnt : '0;
  assign bus.write       = (state_q == WRITE);
  assign bus.write_data  = (state_q == WRITE) ? word_q : '0;
  assign bus.read        = (state_q == READ);
  assign bus.done        = (state_q == RESP);
  assign bus.done_id     = (state_q == RESP) ? id_q : '0;
  assign bus.done_status = (state_q == RESP) ? status_q : OK;
  assign bus.busy        = (state_q != IDLE);
  assign bus.reject_cnt  = reject_cnt_q;

endmodule

// File: tb/tb_shape_processor_cmd_sequencer.sv
// Purpose: randomized and directed checking of the command sequencer against a cycle-numbered model.
// Latency: n/a.
// Backpressure: requesters hold req until gnt, may drop early, may re-request after gnt.
module tb_shape_processor_cmd_sequencer;
  import shape_processor_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shape_processor_cmd_sequencer_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  shape_processor_cmd_sequencer #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus state
  logic [NUM_REQ-1:0] req_v = '0;
  logic [31:0]        data_v [NUM_REQ];
  logic [NUM_REQ-1:0] last_gnt = '0;
  int err_mode = 1;   // 0 random, 1 never, 2 always
  int rd_mode  = 0;   // 0 echo fields, 1 mixed, 2 operation corrupted

  // reference model: event cycles of the command in flight
  int          m_ptr = 0;
  int          gnt_cyc = -10, wr_cyc = -1, rd_cyc = -1, done_cyc = -1, free_at = 0;
  int          m_id = 0, m_status = 0, m_cnt = 0;
  logic [31:0] m_word = '0;

  // observations for directed checks
  int n_done = 0, obs_gnt_cyc = 0, obs_lat = 0, obs_status = 0, obs_id = 0;
  int g_idx_q[$];
  int g_cyc_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic rst_val);
    logic [NUM_REQ-1:0] eg;
    logic [31:0] rd;
    logic e;
    int k;
    int r;
    @(negedge clk);
    rst_n   = rst_val;
    bus.req = req_v;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[32*i +: 32] = data_v[i];
    case (err_mode)
      1:       e = 1'b0;
      2:       e = 1'b1;
      default: e = ($urandom_range(0, 3) == 0);
    endcase
    bus.error = e;
    rd = $urandom;
    if (cyc == rd_cyc) begin
      rd[7:0] = m_word[7:0];
      r = $urandom_range(0, 3);
      if (rd_mode == 2 || (rd_mode == 1 && r == 0)) rd[7:4] = rd[7:4] ^ 4'($urandom_range(1, 15));
      else if (rd_mode == 1 && r == 1)              rd[3:0] = rd[3:0] ^ 4'($urandom_range(1, 15));
    end
    bus.read_data = rd;
    if (!rst_val) begin
      m_ptr = 0; gnt_cyc = -10; wr_cyc = -1; rd_cyc = -1; done_cyc = -1;
      free_at = 0; m_cnt = 0; m_status = 0;
    end
    #1;
    eg = '0;
    k  = -1;
    if (rst_val && cyc >= free_at) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (k < 0 && req_v[(m_ptr + i) % NUM_REQ]) k = (m_ptr + i) % NUM_REQ;
      end
    end
    if (k >= 0) eg[k] = 1'b1;
    check_eq("gnt",         64'(bus.gnt),        64'(eg));
    check_eq("write",       64'(bus.write),      64'(cyc == wr_cyc));
    check_eq("write_data",  64'(bus.write_data), (cyc == wr_cyc) ? 64'(m_word) : 64'd0);
    check_eq("read",        64'(bus.read),       64'(cyc == rd_cyc));
    check_eq("done",        64'(bus.done),       64'(cyc == done_cyc));
    check_eq("done_id",     64'(bus.done_id),    (cyc == done_cyc) ? 64'(m_id) : 64'd0);
    check_eq("done_status", 64'(bus.done_status),(cyc == done_cyc) ? 64'(m_status) : 64'd0);
    check_eq("busy",        64'(bus.busy),       64'(cyc > gnt_cyc && cyc < free_at));
    check_eq("reject_cnt",  64'(bus.reject_cnt), 64'(m_cnt));
    // observations
    if (bus.gnt != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) g_idx_q.push_back(i);
      g_cyc_q.push_back(cyc);
      obs_gnt_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      n_done++;
      obs_lat    = cyc - obs_gnt_cyc;
      obs_status = int'(bus.done_status);
      obs_id     = int'(bus.done_id);
    end
    last_gnt = bus.gnt;
    // model advance
    if (k >= 0) begin
      gnt_cyc = cyc; m_id = k; m_word = data_v[k]; m_ptr = (k + 1) % NUM_REQ;
      wr_cyc = cyc + 1; rd_cyc = -1; done_cyc = -1; free_at = cyc + 1000;
    end else if (cyc == wr_cyc) begin
      if (e) begin
        m_status = 1; done_cyc = cyc + 1; free_at = cyc + 2;
      end else begin
        rd_cyc = cyc + 1; done_cyc = cyc + 2; free_at = cyc + 3;
      end
    end else if (cyc == rd_cyc) begin
      m_status = (rd[7:0] == m_word[7:0]) ? 0 : 2;
    end else if (cyc == done_cyc && m_status == 1 && m_cnt < CNT_MAX) begin
      m_cnt++;
    end
    cyc++;
  endtask

  task automatic run_done(input int max_cyc);
    int base;
    int n;
    base = n_done;
    n    = 0;
    while (n_done == base && n < max_cyc) begin
      step(1'b1);
      n++;
    end
    check_eq("done_seen", 64'(n_done != base), 64'd1);
  endtask

  task automatic update_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_v[i] && last_gnt[i]) begin
        if ($urandom_range(0, 1) == 1) data_v[i] = $urandom;
        else req_v[i] = 1'b0;
      end else if (req_v[i]) begin
        if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_v[i]  = 1'b1;
        data_v[i] = $urandom;
      end
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < NUM_REQ; i++) data_v[i] = '0;
    bus.req = '0; bus.req_data = '0; bus.error = 1'b0; bus.read_data = '0;

    repeat (3) step(1'b0);

    // legal command, clean readback
    data_v[0] = {24'h0, 4'(OP_FILL), 4'(SHAPE_RECT)};
    err_mode = 1; rd_mode = 0; req_v = 4'b0001;
    step(1'b1);
    req_v = '0;
    run_done(6);
    check_eq("t1_latency", 64'(obs_lat), 64'd3);
    check_eq("t1_id",      64'(obs_id),  64'd0);
    check_eq("t1_status",  64'(obs_status), 64'd0);
    step(1'b1);

    // rejected in the write cycle
    data_v[1] = {24'h00abcd, 4'(OP_CLEAR), 4'(SHAPE_TRI)};
    err_mode = 2; req_v = 4'b0010;
    step(1'b1);
    req_v = '0;
    run_done(6);
    check_eq("t2_latency", 64'(obs_lat), 64'd2);
    check_eq("t2_id",      64'(obs_id),  64'd1);
    check_eq("t2_status",  64'(obs_status), 64'd1);
    step(1'b1);
    check_eq("t2_reject_cnt", 64'(bus.reject_cnt), 64'd1);

    // readback OPERATION differs
    data_v[3] = {24'h0, 4'(OP_STROKE), 4'(SHAPE_CIRCLE)};
    err_mode = 1; rd_mode = 2; req_v = 4'b1000;
    step(1'b1);
    req_v = '0;
    run_done(6);
    check_eq("t3_status", 64'(obs_status), 64'd2);
    step(1'b1);
    check_eq("t3_reject_cnt", 64'(bus.reject_cnt), 64'd1);

    // all four requesting continuously
    rd_mode = 0;
    g_idx_q.delete(); g_cyc_q.delete();
    for (int i = 0; i < NUM_REQ; i++) data_v[i] = $urandom;
    req_v = 4'b1111;
    for (int n = 0; n < 40 && g_idx_q.size() < 5; n++) step(1'b1);
    req_v = '0;
    check_eq("t4_grants", 64'(g_idx_q.size() >= 5), 64'd1);
    if (g_idx_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_eq($sformatf("t4_order%0d", i), 64'(g_idx_q[i]), 64'(i % 4));
      for (int i = 1; i < 5; i++) check_eq($sformatf("t4_gap%0d", i), 64'(g_cyc_q[i] - g_cyc_q[i-1]), 64'd4);
    end
    repeat (5) step(1'b1);

    // reset during the read cycle
    req_v = 4'b0001;
    step(1'b1);
    req_v = '0;
    step(1'b1);
    base = n_done;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    req_v = 4'b0100;
    step(1'b1);
    req_v = '0;
    check_eq("t5_gnt_after_reset", 64'(last_gnt), 64'h4);
    check_eq("t5_no_done", 64'(n_done - base), 64'd0);
    repeat (5) step(1'b1);

    // saturate the reject counter
    err_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) data_v[i] = $urandom;
    req_v = 4'b1111;
    repeat (60) step(1'b1);
    req_v = '0;
    repeat (4) step(1'b1);
    check_eq("t6_saturated", 64'(bus.reject_cnt), 64'(CNT_MAX));

    // randomized traffic
    err_mode = 0; rd_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      update_req();
      step($urandom_range(0, 499) != 0);
    end
    req_v = '0;
    repeat (6) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
